// File: rtl/rx_dac_pkg.sv
// Shared types and helpers for the DAC output stage: channel FSM states,
// gain/shift constants and a width-parametrised saturating clip.
package rx_dac_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } ch_state_t;

    function automatic int unity_gain(input int gain_width);
        return 1 << (gain_width - 1);
    endfunction

    // Right shift that removes both the unity gain and the full-scale ramp level.
    function automatic int scale_shift(input int gain_width, input int ramp_log2);
        return gain_width - 1 + ramp_log2;
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] y, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (y > hi) return hi;
        else if (y < lo) return lo;
        else return y;
    endfunction

endpackage

// File: rtl/rx_dac_output_stage_ramp_ctrl.sv
// Per-channel soft-mute controller: ramp FSM, level counter, active gain and
// a one-deep pending gain applied at the bottom of a ramp-down.
module rx_ch_ramp_ctrl
    import rx_dac_pkg::*;
#(
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_LOG2  = 4,
    localparam int SCALE_W   = GAIN_WIDTH + RAMP_LOG2 + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ch_enable,
    input  logic                  cfg_write,
    input  logic [GAIN_WIDTH-1:0] cfg_gain,
    output logic [SCALE_W-1:0]    scale,
    output logic                  ready,
    output ch_state_t             state
);

    localparam int LEVEL_W = RAMP_LOG2 + 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(1 << RAMP_LOG2);
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(GAIN_WIDTH));

    ch_state_t               state_q, state_d;
    logic [LEVEL_W-1:0]      level_q, level_d;
    logic [GAIN_WIDTH-1:0]   gain_q, gain_d;
    logic                    pend_q, pend_d;
    logic [GAIN_WIDTH-1:0]   pend_gain_q, pend_gain_d;
    logic                    step_down;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= MUTED;
            level_q     <= '0;
            gain_q      <= UNITY;
            pend_q      <= 1'b0;
            pend_gain_q <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            gain_q      <= gain_d;
            pend_q      <= pend_d;
            pend_gain_q <= pend_gain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        gain_d      = gain_q;
        pend_d      = pend_q;
        pend_gain_d = pend_gain_q;
        step_down   = 1'b0;
        case (state_q)
            MUTED: begin
                level_d = '0;
                if (cfg_write) gain_d = cfg_gain;
                if (ch_enable) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!ch_enable) begin
                    step_down = 1'b1;
                end else begin
                    level_d = level_q + LEVEL_W'(1);
                    if (level_d == LEVEL_MAX) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cfg_write) begin
                    pend_d      = 1'b1;
                    pend_gain_d = cfg_gain;
                    state_d     = RAMP_DOWN;
                end else if (!ch_enable || pend_q) begin
                    state_d = RAMP_DOWN;
                end
            end
            RAMP_DOWN: step_down = 1'b1;
            default:   state_d = MUTED;
        endcase
        // The down step lands on zero and leaves the ramp in the same edge.
        if (step_down) begin
            if (level_q <= LEVEL_W'(1)) begin
                level_d = '0;
                if (pend_q) begin
                    gain_d = pend_gain_q;
                    pend_d = 1'b0;
                end
                state_d = ch_enable ? RAMP_UP : MUTED;
            end else begin
                level_d = level_q - LEVEL_W'(1);
                state_d = RAMP_DOWN;
            end
        end
    end

    assign scale = SCALE_W'(gain_q) * SCALE_W'(level_q);
    assign ready = ((state_q == MUTED) || (state_q == ACTIVE)) && !pend_q;
    assign state = state_q;

endmodule

// File: rtl/rx_dac_output_stage.sv
// DUC-to-DAC output stage: per-channel gain and soft-mute ramp, 3-stage lane
// pipeline (scale, multiply, shift+clip) and sticky per-channel clip flags.
module rx_dac_output_stage
    import rx_dac_pkg::*;
#(
    parameter int NUMBER_OF_LINE = 8,
    parameter int NUMBER_OF_CH   = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int GAIN_WIDTH     = 8,
    parameter int RAMP_LOG2      = 4,
    localparam int CH_W  = (NUMBER_OF_CH > 1) ? $clog2(NUMBER_OF_CH) : 1,
    localparam int BUS_W = NUMBER_OF_CH * NUMBER_OF_LINE * DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [BUS_W-1:0]        in_data,
    input  logic [NUMBER_OF_CH-1:0] ch_enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [GAIN_WIDTH-1:0]   cfg_gain,
    input  logic                    sat_clear,
    output logic                    out_valid,
    output logic [BUS_W-1:0]        out_data,
    output logic [NUMBER_OF_CH-1:0] ch_active,
    output logic [NUMBER_OF_CH-1:0] sat_flag
);

    localparam int SCALE_W = GAIN_WIDTH + RAMP_LOG2 + 1;
    localparam int PROD_W  = DATA_WIDTH + SCALE_W + 1;
    localparam int SHIFT   = scale_shift(GAIN_WIDTH, RAMP_LOG2);
    localparam int NS      = NUMBER_OF_CH * NUMBER_OF_LINE;

    logic [SCALE_W-1:0]       scale [NUMBER_OF_CH];
    ch_state_t                ch_state [NUMBER_OF_CH];
    logic [NUMBER_OF_CH-1:0]  ch_ready;
    logic [NUMBER_OF_CH-1:0]  cfg_write;

    logic                     v1, v2;
    logic [BUS_W-1:0]         x1;
    logic [SCALE_W-1:0]       s1 [NUMBER_OF_CH];
    logic signed [PROD_W-1:0] prod [NS];
    logic signed [PROD_W-1:0] p2 [NS];
    logic [BUS_W-1:0]         y3;
    logic [NS-1:0]            clip3;
    logic [NUMBER_OF_CH-1:0]  ch_clip;

    // Config handshake: a gain update transfers on any edge where cfg_valid and
    // cfg_ready are both high; cfg_ready never depends on cfg_valid. Channel
    // indices beyond the last channel are always ready and write nothing.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < NUMBER_OF_CH; c++) begin
            if (cfg_ch == CH_W'(c)) cfg_ready = ch_ready[c];
        end
    end

    always_comb begin
        cfg_write = '0;
        for (int c = 0; c < NUMBER_OF_CH; c++) begin
            cfg_write[c] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));
        end
    end

    for (genvar g = 0; g < NUMBER_OF_CH; g++) begin : g_ch
        rx_ch_ramp_ctrl #(
            .GAIN_WIDTH (GAIN_WIDTH),
            .RAMP_LOG2  (RAMP_LOG2)
        ) u_ramp (
            .clock     (clock),
            .reset     (reset),
            .ch_enable (ch_enable[g]),
            .cfg_write (cfg_write[g]),
            .cfg_gain  (cfg_gain),
            .scale     (scale[g]),
            .ready     (ch_ready[g]),
            .state     (ch_state[g])
        );
        assign ch_active[g] = (ch_state[g] == ACTIVE);
    end

    // Scale is unsigned; a zero MSB makes the product signed-by-unsigned.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            prod[i] = PROD_W'($signed(x1[i*DATA_WIDTH +: DATA_WIDTH]))
                    * PROD_W'($signed({1'b0, s1[i / NUMBER_OF_LINE]}));
        end
    end

    always_comb begin : stage3_clip
        logic signed [63:0] y_full;
        logic signed [63:0] y_sat;
        y3      = '0;
        clip3   = '0;
        ch_clip = '0;
        for (int i = 0; i < NS; i++) begin
            y_full = $signed({{(64-PROD_W){p2[i][PROD_W-1]}}, p2[i]}) >>> SHIFT;
            y_sat  = sat_clip(y_full, DATA_WIDTH);
            y3[i*DATA_WIDTH +: DATA_WIDTH] = y_sat[DATA_WIDTH-1:0];
            clip3[i] = (y_sat != y_full);
        end
        for (int c = 0; c < NUMBER_OF_CH; c++) begin
            ch_clip[c] = |clip3[c*NUMBER_OF_LINE +: NUMBER_OF_LINE];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            x1        <= '0;
            out_data  <= '0;
            sat_flag  <= '0;
            for (int c = 0; c < NUMBER_OF_CH; c++) s1[c] <= '0;
            for (int i = 0; i < NS; i++) p2[i] <= '0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            x1        <= in_data;
            out_data  <= y3;
            for (int c = 0; c < NUMBER_OF_CH; c++) s1[c] <= scale[c];
            for (int i = 0; i < NS; i++) p2[i] <= prod[i];
            // A new clip wins over a simultaneous clear.
            sat_flag  <= (sat_flag & ~{NUMBER_OF_CH{sat_clear}}) | (ch_clip & {NUMBER_OF_CH{v2}});
        end
    end

endmodule

// File: tb/tb_rx_dac_output_stage.sv
// Directed bench for rx_dac_output_stage at default parameters
// (unity 128, shift 11, 16-clock ramp).
module tb_rx_dac_output_stage;

    localparam int NL = 8;
    localparam int NC = 3;
    localparam int DW = 16;
    localparam int W  = NL * NC * DW;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [NC-1:0] ch_enable;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [7:0]    cfg_gain;
    logic          sat_clear;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [NC-1:0] ch_active;
    logic [NC-1:0] sat_flag;

    int checks = 0;
    int errors = 0;

    rx_dac_output_stage dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .ch_enable (ch_enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_gain  (cfg_gain),
        .sat_clear (sat_clear),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ch_active (ch_active),
        .sat_flag  (sat_flag)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // all lanes of channel c carry value v<c>
    function automatic logic [W-1:0] pack(input int v0, input int v1, input int v2);
        logic [W-1:0] r;
        int v [NC];
        v[0] = v0;
        v[1] = v1;
        v[2] = v2;
        r = '0;
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < NL; l++)
                r[(c*NL+l)*DW +: DW] = v[c][DW-1:0];
        return r;
    endfunction

    function automatic int lvl(input int k);
        return (k < 0) ? 0 : ((k > 16) ? 16 : k);
    endfunction

    // ch0 output for input 1000 during the 128 -> 64 gain swap; j = edges since accept minus 3
    function automatic int exp_swap(input int j);
        if (j <= 0) return 1000;
        else if (j <= 16) return 1000 * (16 - j) / 16;
        else if (j <= 32) return 1000 * (j - 16) / 32;
        else return 500;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; ch_enable = '0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_gain = '0; sat_clear = 1'b0; in_data = pack(1000, 1000, 1000);
        repeat (3) tick();
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (ch_active !== 3'b000) begin errors++; $display("FAIL reset_ch_active got %b want 000", ch_active); end
        checks++; if (sat_flag !== 3'b000) begin errors++; $display("FAIL reset_sat_flag got %b want 000", sat_flag); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    endtask

    task automatic test_ramp_up();
        logic [W-1:0] exp;
        reset = 1'b0; in_valid = 1'b1; in_data = pack(1000, 700, -300); ch_enable = 3'b001;
        for (int m = 0; m <= 22; m++) begin
            tick();
            exp = pack(1000 * lvl(m - 3) / 16, 0, 0);
            checks++; if (out_data !== exp) begin errors++; $display("FAIL ramp_up_data m=%0d got %h want %h", m, out_data, exp); end
            checks++; if (ch_active !== ((m >= 16) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL ramp_up_active m=%0d got %b", m, ch_active); end
            checks++; if (out_valid !== (m >= 2)) begin errors++; $display("FAIL ramp_up_valid m=%0d got %b", m, out_valid); end
        end
    endtask

    task automatic test_gain_change();
        logic [W-1:0] exp;
        in_data = pack(1000, 1000, 1000);
        cfg_ch = 2'd0; cfg_gain = 8'd64; cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL swap_accept got %b want 1", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        for (int m = 0; m <= 36; m++) begin
            if (m > 0) tick();
            exp = pack(exp_swap(m - 3), 0, 0);
            checks++; if (cfg_ready !== (m >= 32)) begin errors++; $display("FAIL swap_ready m=%0d got %b", m, cfg_ready); end
            checks++; if (out_data !== exp) begin errors++; $display("FAIL swap_data m=%0d got %h want %h", m, out_data, exp); end
            checks++; if ($signed(out_data[15:0]) > 1000) begin errors++; $display("FAIL swap_overshoot m=%0d got %0d want <=1000", m, $signed(out_data[15:0])); end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] exp;
        cfg_ch = 2'd0; cfg_gain = 8'd255; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (35) tick();
        checks++; if (out_data !== pack(1992, 0, 0)) begin errors++; $display("FAIL sat_gain255 got %h", out_data); end
        checks++; if (ch_active !== 3'b001) begin errors++; $display("FAIL sat_active got %b want 001", ch_active); end
        checks++; if (sat_flag !== 3'b000) begin errors++; $display("FAIL sat_idle got %b want 000", sat_flag); end
        in_data = pack(1000, 1000, 1000);
        in_data[15:0] = 16'sd30000;
        in_data[31:16] = -16'sd30000;
        repeat (3) tick();
        exp = pack(1992, 0, 0);
        exp[15:0] = 16'h7fff;
        exp[31:16] = 16'h8000;
        checks++; if (out_data !== exp) begin errors++; $display("FAIL sat_clip_data got %h want %h", out_data, exp); end
        checks++; if (sat_flag !== 3'b001) begin errors++; $display("FAIL sat_set got %b want 001", sat_flag); end
        in_data = pack(1000, 1000, 1000);
        repeat (3) tick();
        checks++; if (out_data !== pack(1992, 0, 0)) begin errors++; $display("FAIL sat_recover got %h", out_data); end
        checks++; if (sat_flag !== 3'b001) begin errors++; $display("FAIL sat_sticky got %b want 001", sat_flag); end
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        checks++; if (sat_flag !== 3'b000) begin errors++; $display("FAIL sat_clear got %b want 000", sat_flag); end
        sat_clear = 1'b1;
        in_data[15:0] = 16'sd30000;
        repeat (3) tick();
        checks++; if (sat_flag !== 3'b001) begin errors++; $display("FAIL sat_clear_vs_clip got %b want 001", sat_flag); end
        sat_clear = 1'b0;
        in_data = pack(1000, 1000, 1000);
    endtask

    task automatic test_reset_mid();
        ch_enable = 3'b110;
        repeat (5) tick();
        checks++; if (sat_flag !== 3'b001) begin errors++; $display("FAIL mid_pre_flag got %b want 001", sat_flag); end
        reset = 1'b1; ch_enable = '0;
        tick();
        checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_reset_data got %h want 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
        checks++; if (ch_active !== 3'b000) begin errors++; $display("FAIL mid_reset_active got %b want 000", ch_active); end
        checks++; if (sat_flag !== 3'b000) begin errors++; $display("FAIL mid_reset_flag got %b want 000", sat_flag); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", cfg_ready); end
        reset = 1'b0; ch_enable = 3'b001;
        repeat (20) tick();
        checks++; if (out_data !== pack(1000, 0, 0)) begin errors++; $display("FAIL mid_unity got %h", out_data); end
        checks++; if (ch_active !== 3'b001) begin errors++; $display("FAIL mid_active got %b want 001", ch_active); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b want 1", out_valid); end
    endtask

    task automatic test_mute_drop();
        int k;
        int l;
        ch_enable = 3'b000;
        repeat (20) tick();
        checks++; if (out_data !== '0) begin errors++; $display("FAIL drop_muted got %h want 0", out_data); end
        ch_enable = 3'b001;
        repeat (9) tick();
        ch_enable = 3'b000;
        for (int n = 9; n <= 24; n++) begin
            tick();
            k = n - 3;
            l = (k <= 8) ? k : ((k >= 16) ? 0 : 16 - k);
            checks++; if (out_data !== pack(1000 * l / 16, 0, 0)) begin errors++; $display("FAIL drop_data n=%0d got %h want level %0d", n, out_data, l); end
            checks++; if (ch_active !== 3'b000) begin errors++; $display("FAIL drop_active n=%0d got %b", n, ch_active); end
        end
        cfg_ch = 2'd0; cfg_gain = 8'd200; cfg_valid = 1'b1;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL muted_cfg_ready got %b want 1", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL muted_cfg_after got %b want 1", cfg_ready); end
        ch_enable = 3'b001;
        repeat (20) tick();
        checks++; if (out_data !== pack(1562, 0, 0)) begin errors++; $display("FAIL muted_gain200 got %h", out_data); end
    endtask

    task automatic test_cfg_routing();
        logic [W-1:0] exp;
        in_data = pack(1000, 1000, 1000);
        ch_enable = 3'b011;
        for (int m = 0; m <= 22; m++) begin
            tick();
            exp = pack(1562, 1000 * lvl(m - 3) / 16, 0);
            checks++; if (out_data !== exp) begin errors++; $display("FAIL route_data m=%0d got %h want %h", m, out_data, exp); end
            checks++; if (ch_active !== ((m >= 16) ? 3'b011 : 3'b001)) begin errors++; $display("FAIL route_active m=%0d got %b", m, ch_active); end
            if (m == 4) begin
                cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_gain = 8'd64;
                #1;
                checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL route_ch2_ready got %b want 1", cfg_ready); end
            end else if (m == 5) begin
                cfg_ch = 2'd3; cfg_gain = 8'd7;
                #1;
                checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL route_ch3_ready got %b want 1", cfg_ready); end
            end else if (m == 6) begin
                cfg_valid = 1'b0; cfg_ch = 2'd0;
            end
        end
        ch_enable = 3'b111;
        repeat (20) tick();
        checks++; if (out_data !== pack(1562, 1000, 500)) begin errors++; $display("FAIL route_final got %h", out_data); end
        checks++; if (ch_active !== 3'b111) begin errors++; $display("FAIL route_final_active got %b want 111", ch_active); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_gain_change();
        test_saturation();
        test_reset_mid();
        test_mute_drop();
        test_cfg_routing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
